// File: rtl/rgb_pkg.sv
// Shared RGB output-path types: colour-wheel phase encoding and its successor function.
package rgb_pkg;

  localparam int HUE_PHASES = 6;

  typedef enum logic [2:0] {
    RISING_GREEN  = 3'd0,
    FALLING_RED   = 3'd1,
    RISING_BLUE   = 3'd2,
    FALLING_GREEN = 3'd3,
    RISING_RED    = 3'd4,
    FALLING_BLUE  = 3'd5
  } hue_state_e;

  function automatic hue_state_e next_phase(input hue_state_e cur);
    hue_state_e nxt;
    case (cur)
      RISING_GREEN:  nxt = FALLING_RED;
      FALLING_RED:   nxt = RISING_BLUE;
      RISING_BLUE:   nxt = FALLING_GREEN;
      FALLING_GREEN: nxt = RISING_RED;
      RISING_RED:    nxt = FALLING_BLUE;
      default:       nxt = RISING_GREEN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gamma_square.sv
// One-channel square-law duty correction, 1 cycle registered; full-on passes through as PEAK.
// No backpressure: samples its input every cycle.
module gamma_square #(
  parameter int WIDTH = 16,
  parameter int PEAK  = 46875,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lin,
  output logic [WIDTH-1:0] sq
);

  localparam int SHIFT = $clog2(PEAK);

  logic [2*WIDTH-1:0] prod;

  assign prod = {{WIDTH{1'b0}}, lin} * {{WIDTH{1'b0}}, lin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sq <= WIDTH'(INIT);
    else if (lin == WIDTH'(PEAK))
      sq <= WIDTH'(PEAK);
    else
      sq <= WIDTH'(prod >> SHIFT);
  end

endmodule

// File: rtl/hue_duty_sequencer.sv
// Colour-wheel duty sequencer stepping on accepted period_end (period_end && enable); no backpressure.
// Outputs valid 1 cycle after an event, 2 with the HUE_SEQ_GAMMA_EN square-law stage.
module hue_duty_sequencer
  import rgb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PEAK  = 46875,
  parameter int STEP  = 92,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             period_end,
  output logic [WIDTH-1:0] duty_r,
  output logic [WIDTH-1:0] duty_g,
  output logic [WIDTH-1:0] duty_b,
  output logic             update,
  output logic [2:0]       phase,
  output logic             hue_wrap
);

  localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [WIDTH-1:0] PEAK_W    = WIDTH'(PEAK);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD - 1);

  hue_state_e       state_q, state_d;
  logic [WIDTH-1:0] ramp_q, ramp_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [WIDTH:0]   ramp_sum;
  logic             accept, wrap_d;
  logic [WIDTH-1:0] fall, lin_r, lin_g, lin_b;
  logic [WIDTH-1:0] lin_r_q, lin_g_q, lin_b_q;
  logic             upd_q, wrap_q;

  assign accept   = period_end && enable;
  assign ramp_sum = {1'b0, ramp_q} + STEP_X;

  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    hold_d  = hold_q;
    wrap_d  = 1'b0;
    if (accept) begin
      if (hold_q != HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
      end else begin
        hold_d = '0;
        if (ramp_q == PEAK_W) begin
          ramp_d  = '0;
          state_d = next_phase(state_q);
          wrap_d  = (state_q == FALLING_BLUE);
        end else if (ramp_sum >= {1'b0, PEAK_W}) begin
          ramp_d = PEAK_W;
        end else begin
          ramp_d = ramp_sum[WIDTH-1:0];
        end
      end
    end
  end

  // Duty words are built from the post-step state so they land with the update strobe.
  always_comb begin
    fall  = PEAK_W - ramp_d;
    lin_r = '0;
    lin_g = '0;
    lin_b = '0;
    case (state_d)
      RISING_GREEN:  begin lin_r = PEAK_W; lin_g = ramp_d; end
      FALLING_RED:   begin lin_r = fall;   lin_g = PEAK_W; end
      RISING_BLUE:   begin lin_g = PEAK_W; lin_b = ramp_d; end
      FALLING_GREEN: begin lin_g = fall;   lin_b = PEAK_W; end
      RISING_RED:    begin lin_r = ramp_d; lin_b = PEAK_W; end
      default:       begin lin_r = PEAK_W; lin_b = fall;   end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RISING_GREEN;
      ramp_q  <= '0;
      hold_q  <= '0;
      lin_r_q <= PEAK_W;
      lin_g_q <= '0;
      lin_b_q <= '0;
      upd_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      hold_q  <= hold_d;
      upd_q   <= accept;
      wrap_q  <= wrap_d;
      if (accept) begin
        lin_r_q <= lin_r;
        lin_g_q <= lin_g;
        lin_b_q <= lin_b;
      end
    end
  end

  assign phase = state_q;

`ifdef HUE_SEQ_GAMMA_EN
  logic upd_g_q, wrap_g_q;

  gamma_square #(.WIDTH(WIDTH), .PEAK(PEAK), .INIT(PEAK)) u_gamma_r (
    .clk(clk), .reset(reset), .lin(lin_r_q), .sq(duty_r));
  gamma_square #(.WIDTH(WIDTH), .PEAK(PEAK), .INIT(0)) u_gamma_g (
    .clk(clk), .reset(reset), .lin(lin_g_q), .sq(duty_g));
  gamma_square #(.WIDTH(WIDTH), .PEAK(PEAK), .INIT(0)) u_gamma_b (
    .clk(clk), .reset(reset), .lin(lin_b_q), .sq(duty_b));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_g_q  <= 1'b0;
      wrap_g_q <= 1'b0;
    end else begin
      upd_g_q  <= upd_q;
      wrap_g_q <= wrap_q;
    end
  end

  assign update   = upd_g_q;
  assign hue_wrap = wrap_g_q;
`else
  assign duty_r   = lin_r_q;
  assign duty_g   = lin_g_q;
  assign duty_b   = lin_b_q;
  assign update   = upd_q;
  assign hue_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_hue_duty_sequencer.sv
// Bench for hue_duty_sequencer: two instances (STEP=5/HOLD=2 and STEP=3/HOLD=1) against an arithmetic wheel model.
module tb_hue_duty_sequencer;

  localparam int PEAK = 10;
`ifdef HUE_SEQ_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset, enable, period_end;
  logic [15:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic        a_upd, a_wrap, b_upd, b_wrap;
  logic [2:0]  a_ph, b_ph;

  int checks = 0;
  int failures = 0;
  int ev_a = 0;
  int ev_b = 0;

  always #5 clk = ~clk;

  hue_duty_sequencer #(.WIDTH(16), .PEAK(PEAK), .STEP(5), .HOLD(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .period_end(period_end),
    .duty_r(a_r), .duty_g(a_g), .duty_b(a_b), .update(a_upd), .phase(a_ph), .hue_wrap(a_wrap));

  hue_duty_sequencer #(.WIDTH(16), .PEAK(PEAK), .STEP(3), .HOLD(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .period_end(period_end),
    .duty_r(b_r), .duty_g(b_g), .duty_b(b_b), .update(b_upd), .phase(b_ph), .hue_wrap(b_wrap));

  function automatic int gam(input int x);
`ifdef HUE_SEQ_GAMMA_EN
    if (x == PEAK) return PEAK;
    return (x * x) >> $clog2(PEAK);
`else
    return x;
`endif
  endfunction

  // Steps per phase: ceil(PEAK/step) ramp steps to reach PEAK, plus one step that rolls the phase.
  function automatic int steps_per_phase(input int step);
    return (PEAK + step - 1) / step + 1;
  endfunction

  function automatic int ph_of(input int step, input int hold, input int ev);
    return ((ev / hold) / steps_per_phase(step)) % 6;
  endfunction

  function automatic int duty_of(input int step, input int hold, input int ev, input int ch);
    int n, s, r;
    int v[3];
    n = steps_per_phase(step);
    s = ev / hold;
    r = (s % n) * step;
    if (r > PEAK) r = PEAK;
    case ((s / n) % 6)
      0:       v = '{PEAK, r, 0};
      1:       v = '{PEAK - r, PEAK, 0};
      2:       v = '{0, PEAK, r};
      3:       v = '{0, PEAK - r, PEAK};
      4:       v = '{r, 0, PEAK};
      default: v = '{PEAK, 0, PEAK - r};
    endcase
    return gam(v[ch]);
  endfunction

  function automatic bit wrap_of(input int step, input int hold, input int ev);
    return (ev > 0) && (ev % hold == 0) && ((ev / hold) % (6 * steps_per_phase(step)) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string tag, input int step, input int hold, input int ev, input bit en,
                            input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                            input logic upd, input logic [2:0] ph, input logic wrp);
    chk({tag, "_r"}, 32'(r), duty_of(step, hold, ev, 0));
    chk({tag, "_g"}, 32'(g), duty_of(step, hold, ev, 1));
    chk({tag, "_b"}, 32'(b), duty_of(step, hold, ev, 2));
    chk({tag, "_phase"}, 32'(ph), ph_of(step, hold, ev));
    chk({tag, "_update"}, 32'(upd), 32'(en));
    chk({tag, "_wrap"}, 32'(wrp), 32'(en && wrap_of(step, hold, ev)));
  endtask

  task automatic check_both(input bit en);
    check_inst("a", 5, 2, ev_a, en, a_r, a_g, a_b, a_upd, a_ph, a_wrap);
    check_inst("b", 3, 1, ev_b, en, b_r, b_g, b_b, b_upd, b_ph, b_wrap);
  endtask

  // n consecutive period_end cycles, then check once outputs for the last event are due.
  task automatic run_evt(input bit en, input int n);
    @(negedge clk);
    chk("a_update_width", 32'(a_upd), 0);
    chk("b_update_width", 32'(b_upd), 0);
    enable = en;
    period_end = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (en) begin
        ev_a++;
        ev_b++;
      end
    end
    period_end = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check_both(en);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_a_r"}, 32'(a_r), PEAK);
    chk({tag, "_a_g"}, 32'(a_g), 0);
    chk({tag, "_a_b"}, 32'(a_b), 0);
    chk({tag, "_a_update"}, 32'(a_upd), 0);
    chk({tag, "_a_phase"}, 32'(a_ph), 0);
    chk({tag, "_a_wrap"}, 32'(a_wrap), 0);
    chk({tag, "_b_r"}, 32'(b_r), PEAK);
    chk({tag, "_b_g"}, 32'(b_g), 0);
    chk({tag, "_b_phase"}, 32'(b_ph), 0);
  endtask

  initial begin
    int lit_b_g[4];
    int lit_a_g2;
`ifdef HUE_SEQ_GAMMA_EN
    lit_b_g  = '{0, 2, 5, 10};
    lit_a_g2 = 1;
`else
    lit_b_g  = '{3, 6, 9, 10};
    lit_a_g2 = 5;
`endif
    reset = 1'b1;
    enable = 1'b1;
    period_end = 1'b0;
    #1;
    check_reset_vals("rst_noclk");
    @(negedge clk);
    reset = 1'b0;

    // One full wheel on instance a (36 events), with literal spot checks.
    for (int i = 1; i <= 36; i++) begin
      run_evt(1'b1, 1);
      if (i == 2) chk("lit_a_g_after2", 32'(a_g), lit_a_g2);
      if (i <= 4) chk($sformatf("lit_b_g_ev%0d", i), 32'(b_g), lit_b_g[i-1]);
      if (i == 5) begin
        chk("lit_b_phase_ev5", 32'(b_ph), 1);
        chk("lit_b_r_ev5", 32'(b_r), PEAK);
      end
      if (i == 6) begin
        chk("lit_a_phase_ev6", 32'(a_ph), 1);
        chk("lit_a_r_ev6", 32'(a_r), PEAK);
        chk("lit_a_g_ev6", 32'(a_g), PEAK);
      end
      if (i == 36) begin
        chk("lit_a_wrap_ev36", 32'(a_wrap), 1);
        chk("lit_a_phase_ev36", 32'(a_ph), 0);
        chk("lit_a_r_ev36", 32'(a_r), PEAK);
      end
    end

    // Frozen: five pulses with enable low, then a pulse on the cycle enable drops.
    run_evt(1'b1, 1);
    repeat (5) run_evt(1'b0, 1);
    run_evt(1'b0, 1);
    run_evt(1'b1, 1);

    // Randomized enables and back-to-back bursts.
    for (int k = 0; k < 150; k++) begin
      run_evt(($urandom_range(0, 3) != 0), $urandom_range(1, 3));
    end

    // Async reset mid-ramp, asserted between clock edges.
    run_evt(1'b1, 3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    ev_a = 0;
    ev_b = 0;
    check_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 1) begin
      @(negedge clk);
      chk("a_update_after_reset", 32'(a_upd), 0);
      chk("b_update_after_reset", 32'(b_upd), 0);
    end
    for (int i = 1; i <= 6; i++) run_evt(1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
